// File: rtl/hub75_framewriter.sv
// HUB75 framebuffer write side: packs a raster-order RGB byte stream to 7-7-6 pixels,
// writes them into the back buffer and swaps buffers on frame_start after a complete frame.
module hub75_framewriter #(
  parameter int unsigned ADDR_WIDTH = 14,
  parameter int unsigned PIXELS     = 16384
) (
  input  logic                  sys_clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  input  logic                  frame_start,
  output logic [19:0]           fb_wdata,
  output logic [ADDR_WIDTH:0]   fb_waddr,
  output logic                  fb_we,
  output logic                  disp_buf,
  output logic                  frame_ready,
  output logic                  frame_err
);

  localparam logic [ADDR_WIDTH-1:0] LastIdx = ADDR_WIDTH'(PIXELS - 1);

  typedef enum logic [2:0] {StHunt, StGetR, StGetG, StGetB, StHold} state_e;

  state_e                state_q;
  logic [ADDR_WIDTH-1:0] pix_q;
  logic [6:0]            r_q;
  logic [6:0]            g_q;
  logic                  acc;

  assign in_ready = (state_q != StHold);
  assign acc      = in_valid && in_ready;

  // Only the colour MSBs survive packing; bit 0 of every byte is discarded.
  logic unused_lsb;
  assign unused_lsb = in_data[0];

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q     <= StHunt;
      pix_q       <= '0;
      r_q         <= '0;
      g_q         <= '0;
      disp_buf    <= 1'b1;
      fb_we       <= 1'b0;
      fb_wdata    <= '0;
      fb_waddr    <= '0;
      frame_ready <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      fb_we     <= 1'b0;
      frame_err <= 1'b0;
      unique case (state_q)
        StHunt: begin
          if (acc && in_sof) begin
            r_q     <= in_data[7:1];
            pix_q   <= '0;
            state_q <= StGetG;
          end
        end
        StGetR, StGetG, StGetB: begin
          if (acc && in_sof) begin
            // Resync: the SOF byte becomes R of pixel 0; partial frame stays unswapped.
            frame_err <= 1'b1;
            r_q       <= in_data[7:1];
            pix_q     <= '0;
            state_q   <= StGetG;
          end else if (acc) begin
            unique case (state_q)
              StGetR: begin
                r_q     <= in_data[7:1];
                state_q <= StGetG;
              end
              StGetG: begin
                g_q     <= in_data[7:1];
                state_q <= StGetB;
              end
              default: begin
                fb_we    <= 1'b1;
                fb_wdata <= {r_q, g_q, in_data[7:2]};
                fb_waddr <= {~disp_buf, pix_q};
                if (pix_q == LastIdx) begin
                  frame_ready <= 1'b1;
                  state_q     <= StHold;
                end else begin
                  pix_q   <= pix_q + ADDR_WIDTH'(1);
                  state_q <= StGetR;
                end
              end
            endcase
          end
        end
        StHold: begin
          if (frame_start) begin
            disp_buf    <= ~disp_buf;
            frame_ready <= 1'b0;
            state_q     <= StHunt;
          end
        end
        default: state_q <= StHunt;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_framewriter.sv
// Directed bench for hub75_framewriter with a 4-pixel frame.
module tb_hub75_framewriter;

  localparam int unsigned AW = 14;

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_sof = 1'b0;
  logic          in_ready;
  logic          frame_start = 1'b0;
  logic [19:0]   fb_wdata;
  logic [AW:0]   fb_waddr;
  logic          fb_we;
  logic          disp_buf;
  logic          frame_ready;
  logic          frame_err;

  int vectors = 0;
  int miscompares = 0;
  int b2b = 0;
  logic prev_we = 1'b0;
  logic [AW:0]  wq_addr[$];
  logic [19:0]  wq_data[$];

  // Frame A: pixels FF/80/07, AA/55/FC, 12/34/56, 01/01/03
  logic [7:0] fa [12] = '{8'hFF, 8'h80, 8'h07, 8'hAA, 8'h55, 8'hFC,
                          8'h12, 8'h34, 8'h56, 8'h01, 8'h01, 8'h03};
  logic [19:0] fa_px [4] = '{20'hFF001, 20'hAAABF, 20'h12695, 20'h00000};

  hub75_framewriter #(.ADDR_WIDTH(AW), .PIXELS(4)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_ready    (in_ready),
    .frame_start (frame_start),
    .fb_wdata    (fb_wdata),
    .fb_waddr    (fb_waddr),
    .fb_we       (fb_we),
    .disp_buf    (disp_buf),
    .frame_ready (frame_ready),
    .frame_err   (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Write monitor, sampled 2 time units after each rising edge.
  always begin
    @(posedge sys_clk);
    #2;
    if (fb_we) begin
      wq_addr.push_back(fb_waddr);
      wq_data.push_back(fb_wdata);
    end
    if (fb_we && prev_we) b2b++;
    prev_we = fb_we;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic sof, input logic fs);
    @(negedge sys_clk);
    in_valid = 1'b1;
    in_data = d;
    in_sof = sof;
    frame_start = fs;
    @(posedge sys_clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      in_valid = 1'b0;
      in_sof = 1'b0;
      frame_start = 1'b0;
    end
  endtask

  task automatic pulse_fs();
    @(negedge sys_clk);
    in_valid = 1'b0;
    frame_start = 1'b1;
    @(negedge sys_clk);
    frame_start = 1'b0;
  endtask

  task automatic send_frame_a(input bit gaps, input bit fs_last);
    for (int i = 0; i < 12; i++) begin
      send(fa[i], (i == 0), fs_last && (i == 11));
      if (gaps) idle(1);
    end
    idle(1);
  endtask

  task automatic check_frame_a(input string tag, input logic [AW:0] base);
    check({tag, "_nwr"}, wq_addr.size(), 4);
    if (wq_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check({tag, "_addr"}, wq_addr[i], base + i);
        check({tag, "_data"}, wq_data[i], fa_px[i]);
      end
    end
  endtask

  task automatic clear_writes();
    wq_addr.delete();
    wq_data.delete();
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_we", fb_we, 0);
    check("rst_wdata", fb_wdata, 0);
    check("rst_waddr", fb_waddr, 0);
    check("rst_disp", disp_buf, 1);
    check("rst_ready", frame_ready, 0);
    check("rst_err", frame_err, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;

    // Junk without SOF is accepted and dropped
    for (int i = 0; i < 5; i++) send(8'h11 * i[7:0], 1'b0, 1'b0);
    idle(2);
    check("junk_nwr", wq_addr.size(), 0);
    check("junk_in_ready", in_ready, 1);

    // Full frame into buffer 0
    send_frame_a(1'b0, 1'b0);
    idle(1);
    check_frame_a("f1", 15'h0000);
    check("f1_ready", frame_ready, 1);
    check("f1_in_ready", in_ready, 0);
    check("f1_err", frame_err, 0);
    idle(3);
    check("hold_disp", disp_buf, 1);

    // Swap on frame_start in HOLD
    pulse_fs();
    check("swap_disp", disp_buf, 0);
    check("swap_ready", frame_ready, 0);
    check("swap_in_ready", in_ready, 1);
    pulse_fs();
    check("fs_hunt_noswap", disp_buf, 0);

    // Next frame writes buffer 1; frame_start coinciding with last B is ignored
    clear_writes();
    send_frame_a(1'b0, 1'b1);
    idle(1);
    check_frame_a("f2", 15'h4000);
    check("f2_ready", frame_ready, 1);
    idle(2);
    check("f2_noswap", disp_buf, 0);
    pulse_fs();
    check("f2_swap", disp_buf, 1);

    // Early SOF resync
    clear_writes();
    send(8'hFF, 1'b1, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    send(8'h07, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0);
    send(8'h55, 1'b0, 1'b0);
    #1 check("resync_err_idle", frame_err, 0);
    send(8'h12, 1'b1, 1'b0);
    #1 check("resync_err", frame_err, 1);
    send(8'h34, 1'b0, 1'b0);
    #1 check("resync_err_clr", frame_err, 0);
    send(8'h56, 1'b0, 1'b0);
    send(8'hFF, 1'b0, 1'b0); send(8'h80, 1'b0, 1'b0); send(8'h07, 1'b0, 1'b0);
    send(8'hAA, 1'b0, 1'b0); send(8'h55, 1'b0, 1'b0); send(8'hFC, 1'b0, 1'b0);
    send(8'h01, 1'b0, 1'b0); send(8'h01, 1'b0, 1'b0); send(8'h03, 1'b0, 1'b0);
    idle(2);
    check("resync_nwr", wq_addr.size(), 5);
    if (wq_addr.size() == 5) begin
      check("resync_a0", wq_addr[0], 15'h0000);
      check("resync_d0", wq_data[0], 20'hFF001);
      check("resync_a1", wq_addr[1], 15'h0000);
      check("resync_d1", wq_data[1], 20'h12695);
      check("resync_a2", wq_addr[2], 15'h0001);
      check("resync_d2", wq_data[2], 20'hFF001);
      check("resync_a3", wq_addr[3], 15'h0002);
      check("resync_d3", wq_data[3], 20'hAAABF);
      check("resync_a4", wq_addr[4], 15'h0003);
      check("resync_d4", wq_data[4], 20'h00000);
    end
    check("resync_disp", disp_buf, 1);
    check("resync_ready", frame_ready, 1);
    pulse_fs();
    check("resync_swap", disp_buf, 0);

    // Reset mid-pixel, coinciding with the B byte
    clear_writes();
    send(8'hFF, 1'b1, 1'b0);
    send(8'h80, 1'b0, 1'b0);
    @(negedge sys_clk);
    rst = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h07;
    in_sof = 1'b0;
    @(posedge sys_clk);
    #1;
    check("mrst_we", fb_we, 0);
    check("mrst_disp", disp_buf, 1);
    check("mrst_ready", frame_ready, 0);
    @(negedge sys_clk);
    rst = 1'b0;
    in_valid = 1'b0;
    idle(1);
    check("mrst_nwr", wq_addr.size(), 0);
    check("mrst_in_ready", in_ready, 1);

    // Gapped frame after reset: same writes as the first frame, never back-to-back
    b2b = 0;
    send_frame_a(1'b1, 1'b0);
    idle(1);
    check_frame_a("gap", 15'h0000);
    check("gap_b2b", b2b, 0);
    check("gap_ready", frame_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
